// File: rtl/draw_line_arb_if.sv
// Request/engine bus between two line-command clients, the arbiter and one line engine.
// master = the requesters plus the engine; slave = the arbiter.
interface draw_line_arb_if #(
    parameter int CORDW = 10
);
    logic                    req0_valid;
    logic                    req0_ready;
    logic signed [CORDW-1:0] req0_x0;
    logic signed [CORDW-1:0] req0_y0;
    logic signed [CORDW-1:0] req0_x1;
    logic signed [CORDW-1:0] req0_y1;
    logic                    req0_done;

    logic                    req1_valid;
    logic                    req1_ready;
    logic signed [CORDW-1:0] req1_x0;
    logic signed [CORDW-1:0] req1_y0;
    logic signed [CORDW-1:0] req1_x1;
    logic signed [CORDW-1:0] req1_y1;
    logic                    req1_done;

    logic                    ln_start;
    logic signed [CORDW-1:0] ln_x0;
    logic signed [CORDW-1:0] ln_y0;
    logic signed [CORDW-1:0] ln_x1;
    logic signed [CORDW-1:0] ln_y1;
    logic                    ln_done;

    modport master (
        output req0_valid, req0_x0, req0_y0, req0_x1, req0_y1,
        output req1_valid, req1_x0, req1_y0, req1_x1, req1_y1,
        output ln_done,
        input  req0_ready, req0_done, req1_ready, req1_done,
        input  ln_start, ln_x0, ln_y0, ln_x1, ln_y1
    );

    modport slave (
        input  req0_valid, req0_x0, req0_y0, req0_x1, req0_y1,
        input  req1_valid, req1_x0, req1_y0, req1_x1, req1_y1,
        input  ln_done,
        output req0_ready, req0_done, req1_ready, req1_done,
        output ln_start, ln_x0, ln_y0, ln_x1, ln_y1
    );
endinterface

// File: rtl/draw_line_arb.sv
// Round-robin arbiter/sequencer feeding one Bresenham line engine from two clients.
//   state   | meaning
//   S_IDLE  | no command owned; grant/ready active, accepts a command
//   S_START | command latched; ln_start high for this single cycle
//   S_WAIT  | engine running; coordinates held until ln_done
module draw_line_arb #(
    parameter int CORDW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    draw_line_arb_if.slave        bus,
    output logic                  busy,
    output logic                  owner
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t state, state_nxt;

    logic                    last;
    logic                    grant;
    logic                    ready0, ready1, xfer;
    logic                    done0, done1;
    logic                    ln_start;
    logic signed [CORDW-1:0] x0, y0, x1, y1;

    // Exactly one valid wins outright; with both (or neither) valid, favour the non-last one.
    always_comb begin
        grant = ~last;
        if (bus.req0_valid && !bus.req1_valid)
            grant = 1'b0;
        else if (bus.req1_valid && !bus.req0_valid)
            grant = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (xfer) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (bus.ln_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready0   = (state == S_IDLE) && !grant && bus.req0_valid;
        ready1   = (state == S_IDLE) &&  grant && bus.req1_valid;
        xfer     = ready0 || ready1;
        ln_start = (state == S_START);
        busy     = (state != S_IDLE);
    end

    // Command latch and registered completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            last  <= 1'b1;
            owner <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            x0    <= '0;
            y0    <= '0;
            x1    <= '0;
            y1    <= '0;
        end else begin
            done0 <= (state == S_WAIT) && bus.ln_done && !owner;
            done1 <= (state == S_WAIT) && bus.ln_done &&  owner;
            if (xfer) begin
                owner <= grant;
                last  <= grant;
                x0    <= grant ? bus.req1_x0 : bus.req0_x0;
                y0    <= grant ? bus.req1_y0 : bus.req0_y0;
                x1    <= grant ? bus.req1_x1 : bus.req0_x1;
                y1    <= grant ? bus.req1_y1 : bus.req0_y1;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.req0_done  = done0;
    assign bus.req1_done  = done1;
    assign bus.ln_start   = ln_start;
    assign bus.ln_x0      = x0;
    assign bus.ln_y0      = y0;
    assign bus.ln_x1      = x1;
    assign bus.ln_y1      = y1;
endmodule

// File: tb/tb_draw_line_arb.sv
// Directed bench for draw_line_arb: the bench plays both requesters and the line engine.
module tb_draw_line_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, owner;
    int   n_tests = 0;
    int   n_fail  = 0;

    draw_line_arb_if #(.CORDW(10)) bus ();

    draw_line_arb #(.CORDW(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run after they settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic engine_run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
        bus.ln_done = 1'b1;
        tick();
        bus.ln_done = 1'b0;
        #1;
    endtask

    task automatic set_req0(input int v, input int a, input int b, input int c, input int d);
        bus.req0_valid = v[0];
        bus.req0_x0 = 10'(a); bus.req0_y0 = 10'(b);
        bus.req0_x1 = 10'(c); bus.req0_y1 = 10'(d);
    endtask

    task automatic set_req1(input int v, input int a, input int b, input int c, input int d);
        bus.req1_valid = v[0];
        bus.req1_x0 = 10'(a); bus.req1_y0 = 10'(b);
        bus.req1_x1 = 10'(c); bus.req1_y1 = 10'(d);
    endtask

    initial begin
        bus.ln_done = 1'b0;
        set_req0(0, 0, 0, 0, 0);
        set_req1(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_busy",   busy, 0);
        check("rst_owner",  owner, 0);
        check("rst_start",  bus.ln_start, 0);
        check("rst_x0",     bus.ln_x0, 0);
        check("rst_y1",     bus.ln_y1, 0);
        check("rst_done0",  bus.req0_done, 0);

        // Single request from requester 0.
        set_req0(1, 10, 20, 15, 25);
        #1;
        check("s_ready0", bus.req0_ready, 1);
        check("s_ready1", bus.req1_ready, 0);
        tick();
        set_req0(0, 0, 0, 0, 0);
        #1;
        check("s_start", bus.ln_start, 1);
        check("s_x0", bus.ln_x0, 10);
        check("s_y0", bus.ln_y0, 20);
        check("s_x1", bus.ln_x1, 15);
        check("s_y1", bus.ln_y1, 25);
        check("s_busy", busy, 1);
        tick();
        check("s_start_off", bus.ln_start, 0);
        engine_run(3);
        check("s_done0", bus.req0_done, 1);
        check("s_busy_clr", busy, 0);
        tick();
        check("s_done0_once", bus.req0_done, 0);
        check("s_hold_x1", bus.ln_x1, 15);

        // Simultaneous requests after a completed req0 (last=0): req1 wins first.
        set_req0(1, 1, 2, 3, 4);
        set_req1(1, 7, 8, 9, 6);
        #1;
        check("sim_ready1", bus.req1_ready, 1);
        check("sim_ready0", bus.req0_ready, 0);
        tick();
        set_req1(0, 0, 0, 0, 0);
        #1;
        check("sim_owner1", owner, 1);
        check("sim_x0_b", bus.ln_x0, 7);
        tick();
        check("sim_noready", bus.req0_ready, 0);
        engine_run(2);
        check("sim_done1", bus.req1_done, 1);
        check("sim_ready0_b2b", bus.req0_ready, 1);
        tick();
        set_req0(0, 0, 0, 0, 0);
        #1;
        check("sim_owner0", owner, 0);
        check("sim_x0_a", bus.ln_x0, 1);
        check("sim_y1_a", bus.ln_y1, 4);
        tick();
        engine_run(1);
        check("sim_done0", bus.req0_done, 1);
        check("sim_done1_quiet", bus.req1_done, 0);

        // Fairness: both held valid for 4 commands; last=0 so order is 1,0,1,0.
        set_req0(1, 5, 5, 6, 6);
        set_req1(1, 2, 2, 3, 3);
        #1;
        for (int i = 0; i < 4; i++) begin
            int exp_own;
            exp_own = (i % 2 == 0) ? 1 : 0;
            check("fair_ready0", bus.req0_ready, 1 - exp_own);
            check("fair_ready1", bus.req1_ready, exp_own);
            tick();
            check("fair_owner", owner, exp_own);
            check("fair_busy_nordy", bus.req0_ready | bus.req1_ready, 0);
            tick();
            check("fair_wait_nordy", bus.req0_ready | bus.req1_ready, 0);
            engine_run(1);
            check("fair_done", exp_own ? bus.req1_done : bus.req0_done, 1);
        end
        set_req0(0, 0, 0, 0, 0);
        set_req1(0, 0, 0, 0, 0);
        tick();

        // Negative coordinates via requester 1.
        set_req1(1, -5, -3, 4, -3);
        #1;
        check("neg_ready1", bus.req1_ready, 1);
        tick();
        set_req1(0, 0, 0, 0, 0);
        #1;
        check("neg_x0", bus.ln_x0, -5);
        check("neg_y0", bus.ln_y0, -3);
        check("neg_x1", bus.ln_x1, 4);
        tick(); tick();
        check("neg_wait_y1", bus.ln_y1, -3);
        check("neg_wait_x0", bus.ln_x0, -5);
        engine_run(0);
        check("neg_done1", bus.req1_done, 1);

        // Spurious ln_done while idle.
        tick();
        bus.ln_done = 1'b1;
        tick();
        bus.ln_done = 1'b0;
        #1;
        check("spur_busy", busy, 0);
        check("spur_start", bus.ln_start, 0);
        tick();
        check("spur_done0", bus.req0_done, 0);
        check("spur_done1", bus.req1_done, 0);

        // Reset during WAIT, then simultaneous request grants requester 0.
        set_req1(1, 9, 9, 1, 1);
        tick();
        set_req1(0, 0, 0, 0, 0);
        tick();
        check("rw_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_start", bus.ln_start, 0);
        check("rw_owner", owner, 0);
        check("rw_x0", bus.ln_x0, 0);
        bus.ln_done = 1'b1;
        tick();
        bus.ln_done = 1'b0;
        check("rw_nodone0", bus.req0_done, 0);
        check("rw_nodone1", bus.req1_done, 0);
        set_req0(1, 3, 3, 3, 3);
        set_req1(1, 4, 4, 4, 4);
        #1;
        check("rw_ready0", bus.req0_ready, 1);
        check("rw_ready1", bus.req1_ready, 0);
        tick();
        set_req0(0, 0, 0, 0, 0);
        set_req1(0, 0, 0, 0, 0);
        #1;
        check("rw_owner0", owner, 0);
        check("rw_degen_x1", bus.ln_x1, 3);
        check("rw_start2", bus.ln_start, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/draw_line_arb.md
Name: draw_line_arb

Overview:
- Two-requester arbiter/sequencer in front of a single Bresenham line-drawing engine (start/done handshake, signed CORDW coordinates).
- Accepts line commands from two independent clients (e.g. shape renderer and debug overlay) using round-robin arbitration.
- Latches the winning command, pulses the engine's start, holds the coordinates stable until the engine reports done, then returns a one-cycle completion pulse to the owning requester.

Parameters:
- CORDW, 10, signed coordinate width; must match the line engine.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 has a line command
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_x0, req0_y0, req0_x1, req0_y1  in  CORDW each  requester 0 endpoints, signed
- req0_done  out  1  requester 0 line finished; one-cycle pulse
- req1_valid, req1_ready, req1_x0/y0/x1/y1, req1_done  same as requester 0, for requester 1
- ln_start  out  1  start pulse to the line engine
- ln_x0, ln_y0, ln_x1, ln_y1  out  CORDW each  endpoints driven to the engine
- ln_done  in  1  engine line complete; one-cycle pulse
- busy  out  1  a command is owned (START or WAIT state)
- owner  out  1  index of the current or most recent owner

Behaviour:
- Reset: state IDLE. ln_start, req0_done, req1_done, busy, owner, and ln_x0/ln_y0/ln_x1/ln_y1 all 0. Round-robin pointer last=1, so requester 0 has priority first.
- Grant is combinational in IDLE only:
  - If exactly one valid is high, that requester wins.
  - If both are high, the requester other than last wins.
- reqN_ready = (state==IDLE) && grant==N && reqN_valid. Never high outside IDLE; at most one ready per cycle.
- Transfer occurs when valid and ready are both high. Requesters hold valid and coordinates stable until ready. Deasserting valid before acceptance is legal; that requester is then simply not served.
- FSM:
  - IDLE: on transfer, latch the winner's four coordinates into ln_*, set owner=winner, last=winner, busy=1, go to START. With no valid, stay in IDLE.
  - START: ln_start=1 for exactly this one cycle; go to WAIT.
  - WAIT: ln_start=0, coordinates held. On ln_done, pulse reqN_done (N=owner) in the next cycle (registered), clear busy, go to IDLE.
- Timing:
  - Acceptance to ln_start: 1 cycle.
  - ln_done to reqN_done: 1 cycle.
  - Back-to-back commands: the next acceptance can occur in the cycle the done pulse is high. Minimum gap between ln_start pulses = engine runtime + 2 cycles.
- ln_done outside WAIT is ignored: no done pulse, no state change.
- ln_x0/ln_y0/ln_x1/ln_y1 change only at acceptance and retain their last value when idle.
- Coordinates pass through unmodified and without sign or width changes. Degenerate lines (x0==x1 and y0==y1) are forwarded normally.
- owner stays valid after completion until the next acceptance.
- Reset mid-operation (START or WAIT): return to the reset state immediately. No done pulse is issued for the aborted command. The engine shares rst and aborts as well.
- No timeout: WAIT persists until ln_done or rst.

Test Plan:
- Single request: after reset, req0 (10,20)->(15,25) valid -> req0_ready in cycle 1; ln_start 1 cycle later with ln_x0=10, ln_y0=20, ln_x1=15, ln_y1=25; after ln_done, req0_done pulses once, busy=0.
- Simultaneous requests after reset: req0 and req1 both valid -> req0 served first (owner=0); req1 accepted in the req0_done cycle; order 0,1.
- Fairness: both requesters held valid continuously for 4 commands -> grants alternate 0,1,0,1; no ready while busy.
- Negative coordinates: req1 (-5,-3)->(4,-3) -> ln_* outputs equal -5, -3, 4, -3 in two's complement, held through WAIT.
- Spurious ln_done in IDLE with no requests -> no reqN_done, state stays IDLE.
- rst asserted in WAIT -> next cycle busy=0, ln_start=0, no done pulse; a following simultaneous request grants requester 0.
